// File: rtl/mux_arbiter.sv
// Round-robin arbiter for 8 requesters driving a shared 8-to-1 bit mux.
// Latency: one cycle from req to registered grant/sel/valid; c is combinational from them.
// A grant ends on release or after HOLD_CYCLES cycles, and re-arbitration happens on the same edge.
module mux_arbiter #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  input  logic [7:0] x,
  output logic [7:0] grant,
  output logic [2:0] sel,
  output logic       valid,
  output logic       c
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  localparam logic [3:0] LAST_COUNT = 4'(HOLD_CYCLES - 1);

  state_t     state, state_nxt;
  logic [2:0] ptr, ptr_nxt;
  logic [2:0] sel_nxt;
  logic [3:0] count, count_nxt;
  logic [7:0] grant_nxt;

  logic       found;
  logic [2:0] winner;
  logic [2:0] idx;
  logic       grant_end;
  logic       rearb;

  // Rotating priority search: scan from the farthest index back to ptr so the first hit wins.
  always_comb begin
    found  = 1'b0;
    winner = ptr;
    idx    = ptr;
    for (int k = 7; k >= 0; k--) begin
      idx = ptr + 3'(k);
      if (req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  // A grant ends when the owner drops its request or its hold window is used up.
  always_comb begin
    grant_end = (state == GRANT) && (!req[sel] || (count == LAST_COUNT));
    rearb     = (state == IDLE) || grant_end;
  end

  // State register together with the registered grant datapath.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= 3'd0;
      sel   <= 3'd0;
      count <= 4'd0;
      grant <= 8'd0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      sel   <= sel_nxt;
      count <= count_nxt;
      grant <= grant_nxt;
    end
  end

  // Next-state and next-datapath values: hand over, go idle, or keep counting the hold.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    sel_nxt   = sel;
    count_nxt = count;
    grant_nxt = grant;
    if (rearb) begin
      if (found) begin
        state_nxt = GRANT;
        grant_nxt = 8'(1) << winner;
        sel_nxt   = winner;
        count_nxt = 4'd0;
        ptr_nxt   = winner + 3'd1;
      end else begin
        state_nxt = IDLE;
        grant_nxt = 8'd0;
        count_nxt = 4'd0;
      end
    end else begin
      count_nxt = count + 4'd1;
    end
  end

  // Outputs derived from registered state: valid tracks GRANT, c is the gated mux bit.
  always_comb begin
    valid = (state == GRANT);
    c     = valid ? x[sel] : 1'b0;
  end

endmodule

// File: doc/mux_arbiter.md
MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 Parameter HOLD_CYCLES, default 4, sets the maximum consecutive cycles one requester keeps the mux while others wait; legal range 1..15.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset; one clock, reset is synchronous and active-high.
REQ-004 req  input  8  request lines; req[i] high means requester i wants the shared 8-to-1 mux.
REQ-005 x  input  8  data bits; x[i] is requester i's data into the shared mux.
REQ-006 grant  output  8  registered one-hot grant; all-zero when no owner.
REQ-007 sel  output  3  registered mux select, binary index of granted requester.
REQ-008 valid  output  1  high while a grant is active (state GRANT).
REQ-009 c  output  1  shared mux output: x[sel] when valid, else 0 (combinational from registered sel/valid).

Function
REQ-010 The block SHALL implement a two-state FSM: IDLE (no owner) and GRANT (one owner).
REQ-011 The block SHALL keep a 3-bit round-robin pointer ptr, indicating the highest-priority index for the next arbitration.
REQ-012 Arbitration SHALL select the first index i with req[i]=1 in the order ptr, ptr+1, ..., ptr+7 (mod 8).
REQ-013 In IDLE, if any req bit is 1 at an edge, the block SHALL enter GRANT at that edge with grant=one-hot(winner), sel=winner, valid=1, count=0, ptr=winner+1 mod 8 (latency 1 cycle, req to grant).
REQ-014 In IDLE with req=0, all outputs SHALL hold at grant=0, valid=0, c=0; sel and ptr retain their values.
REQ-015 In GRANT, count SHALL increment by 1 each edge with no release and no timeout.
REQ-016 Release: req[sel]=0 at an edge in GRANT SHALL end the current grant at that edge.
REQ-017 Timeout: count=HOLD_CYCLES-1 at an edge in GRANT SHALL end the current grant at that edge, so that one grant lasts at most HOLD_CYCLES cycles.
REQ-018 When a grant ends, the block SHALL re-arbitrate in the same edge (REQ-012, using the ptr that is already sel+1) with no dead cycle.
REQ-018a On re-arbitration, if a winner exists the block SHALL issue that grant per REQ-013.
REQ-018b On re-arbitration, if no winner exists the block SHALL enter IDLE with grant=0, valid=0.
REQ-019 On timeout with only the current owner requesting, that owner SHALL be re-granted with count reset to 0 and ptr unchanged.
REQ-020 Release and timeout at the same edge SHALL behave as a single grant end.
REQ-021 A req rising for a non-owner during GRANT SHALL NOT preempt; it is served only at release or timeout.
REQ-022 grant SHALL never have more than one bit set; grant[sel]=1 whenever valid=1.
REQ-023 count SHALL be 4 bits and SHALL never exceed HOLD_CYCLES-1.

Reset
REQ-024 reset=1 at an edge SHALL force state=IDLE, ptr=0, sel=0, count=0, grant=0, valid=0 (hence c=0), regardless of the current state.
REQ-025 reset SHALL take priority over release, timeout and new requests at the same edge.
REQ-026 After reset deasserts, the first arbitration SHALL use ptr=0.

Verification
REQ-027 Reset then req=8'h04 -> one edge later grant=8'h04, sel=2, valid=1; with x=8'h04 then c=1, with x=8'h00 then c=0.
REQ-028 req=8'hFF held, HOLD_CYCLES=4, from reset -> grants go to 0,1,2,...,7,0, each for exactly 4 cycles, with no gap cycles.
REQ-029 Owner 3 drops req after 2 cycles while req[5]=1 -> on the release edge grant=8'h20, sel=5, with no IDLE cycle.
REQ-030 Only req[6]=1 held for 10 cycles, HOLD_CYCLES=4 -> grant stays 8'h40 continuously, count wraps 0..3, and valid never drops.
REQ-031 Mid-grant (sel=5, count=2) reset pulsed for 1 cycle with req=8'hFF -> after the reset edge grant=0 and valid=0; on the next edge grant=8'h01.
REQ-032 Last owner releases with req=0 -> next edge valid=0, grant=0, c=0 for any x.
